// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Purpose  : MIPS GPR file with two bypassed read ports and an in-flight
//            write scoreboard that raises stall_req on uncovered hazards.
//            Optional debug read port enabled by REGFILE_DBG_PORT_EN.
// Revision : 1.0  initial release
// ============================================================================
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic              issue_we,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic              flush,
`ifdef REGFILE_DBG_PORT_EN
    output logic              stall_req,
    output logic              sb_ovf,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
`else
    output logic              stall_req,
    output logic              sb_ovf
`endif
);

    localparam int             c_NREG    = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [DATA_W-1:0] r_regs [c_NREG];
    logic [CNT_W-1:0]  r_cnt  [c_NREG];
    logic              r_sb_ovf;

    logic w_wr_ok;
    logic w_inc;
    logic w_dec;
    logic w_same;
    logic w_hz1;
    logic w_hz2;

    assign w_wr_ok = we && (waddr != '0);
    assign w_inc   = issue_we && (issue_addr != '0);
    assign w_dec   = w_wr_ok && (r_cnt[waddr] != '0);
    assign w_same  = w_inc && w_dec && (issue_addr == waddr);

    always_comb begin
        rdata1 = '0;
        if (!rst && re1 && (raddr1 != '0)) begin
            if (we && (waddr == raddr1)) rdata1 = wdata;
            else                         rdata1 = r_regs[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (!rst && re2 && (raddr2 != '0)) begin
            if (we && (waddr == raddr2)) rdata2 = wdata;
            else                         rdata2 = r_regs[raddr2];
        end
    end

    // The last outstanding producer retiring this cycle is covered by bypass.
    assign w_hz1 = re1 && (raddr1 != '0) && (r_cnt[raddr1] != '0)
                   && !((r_cnt[raddr1] == c_CNT_ONE) && we && (waddr == raddr1));
    assign w_hz2 = re2 && (raddr2 != '0) && (r_cnt[raddr2] != '0)
                   && !((r_cnt[raddr2] == c_CNT_ONE) && we && (waddr == raddr2));

    assign stall_req = !rst && (w_hz1 || w_hz2);
    assign sb_ovf    = r_sb_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_NREG; i++) r_regs[i] <= '0;
        end else if (w_wr_ok) begin
            r_regs[waddr] <= wdata;
        end
    end

    // Flush wins over issue; a matched inc/dec on one register cancels out.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_NREG; i++) r_cnt[i] <= '0;
            r_sb_ovf <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < c_NREG; i++) r_cnt[i] <= '0;
        end else begin
            if (w_inc && !w_same) begin
                if (r_cnt[issue_addr] == c_CNT_MAX) r_sb_ovf <= 1'b1;
                else r_cnt[issue_addr] <= r_cnt[issue_addr] + c_CNT_ONE;
            end
            if (w_dec && !w_same) begin
                r_cnt[waddr] <= r_cnt[waddr] - c_CNT_ONE;
            end
        end
    end

`ifdef REGFILE_DBG_PORT_EN
    assign dbg_data = (rst || (dbg_addr == '0)) ? '0 : r_regs[dbg_addr];
`else
`endif

endmodule
`default_nettype wire

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- General-purpose register file for the 5-stage MIPS pipeline.
- Acts as the responder to the decode stage's two read requests (enable + address) and accepts the write-back stage's write.
- Adds a per-register in-flight write scoreboard. Decode marks a destination register at issue; write-back retires it. The block raises stall_req when a read source still has an outstanding producer that bypass cannot cover.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; 2**ADDR_W registers
- CNT_W, 2, width of each register's in-flight counter (max 3 outstanding writes)

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- we  in  1  write enable from write-back
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- re1  in  1  read port 1 enable
- raddr1  in  ADDR_W  read port 1 address (rs)
- rdata1  out  DATA_W  read port 1 data, combinational
- re2  in  1  read port 2 enable
- raddr2  in  ADDR_W  read port 2 address (rt)
- rdata2  out  DATA_W  read port 2 data, combinational
- issue_we  in  1  decode issues an instruction that will write issue_addr
- issue_addr  in  ADDR_W  destination of the issued instruction
- flush  in  1  pipeline flush; clears all in-flight counters
- stall_req  out  1  decode must hold; combinational
- sb_ovf  out  1  sticky error, registered: issue hit a saturated counter

Behaviour:
- Reset: synchronous when rst=1 at the clock edge.
  - All registers, all counters and sb_ovf become 0.
  - While rst=1, rdata1, rdata2 and stall_req are forced to 0.
- Write: at the clock edge when we=1 and waddr!=0, reg[waddr] <= wdata. Writes to $0 are discarded; $0 always reads 0.
- Read, port n (combinational, zero latency), evaluated in priority order:
  - rst=1 -> 0
  - ren=0 -> 0
  - raddrn=0 -> 0
  - we=1 and waddr==raddrn -> wdata (write-through bypass)
  - otherwise -> reg[raddrn]
- Scoreboard: cnt[r] of CNT_W bits per register; cnt[0] is held at 0.
  - inc = issue_we and issue_addr!=0
  - dec = we and waddr!=0 and cnt[waddr]!=0
  - If inc and dec target the same register: cnt is unchanged.
  - Otherwise inc adds 1 to cnt[issue_addr], and dec subtracts 1 from cnt[waddr]. Different registers update in the same cycle.
  - Write-back to a register whose cnt==0: the data is written and the counter stays at 0, with no error.
  - inc when cnt[issue_addr] is at its maximum (all ones): the counter holds and sb_ovf is set to 1 and stays set until rst.
  - flush=1: all counters become 0 at the edge. A simultaneous write still updates data. A simultaneous issue is ignored (flush has priority).
- Stall: stall_req = hz1 | hz2.
  - hzn = ren and raddrn!=0 and cnt[raddrn]!=0, and NOT (cnt[raddrn]==1 and we and waddr==raddrn).
  - That is, the last outstanding producer being written this cycle is covered by bypass.
  - stall_req does not gate issue_we; decode must drop issue_we while stalled.

Optional Feature:
- Macro REGFILE_DBG_PORT_EN.
- Defined: adds input dbg_addr (ADDR_W) and output dbg_data (DATA_W).
  - dbg_data = reg[dbg_addr], combinational, with no bypass.
  - dbg_addr=0 returns 0; rst=1 returns 0.
  - It has no effect on the scoreboard or stall_req.
- Not defined: the ports do not exist and all other behaviour is identical.

Test Plan:
- Reset then read: rst=1 one cycle; then re1=1, raddr1=5 -> rdata1=0, stall_req=0, sb_ovf=0.
- Write then read, bypass: we=1, waddr=3, wdata=0x1234_5678 with re2=1, raddr2=3 in the same cycle -> rdata2=0x1234_5678 immediately. Next cycle with we=0 -> rdata2 is still 0x1234_5678.
- $0 protection: we=1, waddr=0, wdata=0xFFFF_FFFF; issue_we=1, issue_addr=0 -> read of $0 returns 0, stall_req=0.
- Scoreboard hazard:
  - Issue addr 8 for cycle 1, then reading raddr1=8 with re1=1 -> stall_req=1.
  - In the cycle we=1, waddr=8 -> stall_req=0 and rdata1=wdata.
  - Next cycle -> cnt[8]=0, stall_req=0.
- Multiple producers and saturation:
  - Issue addr 9 three times -> cnt=3; a WB write to 9 -> still stalled (cnt goes 3 to 2).
  - A 4th issue to 9 while at 3 -> sb_ovf=1 and stays 1 until rst.
- Flush mid-flight: cnt[4]=2 and flush=1 concurrent with we=1, waddr=4, wdata=0xA5 and issue to 4 -> next cycle cnt[4]=0, reg[4]=0xA5, stall_req=0 for a read of 4.
